// File: rtl/beat_timer.sv
// beat_timer: beat/phase generator for a three-beat instruction cycle.
//
// Each beat is three clocks of one-hot phase T (T1,T2,T3). At the end of T3
// the next beat W is chosen from the controller inputs SHORT/LONG/STOP. A
// synchronized rising edge on the QD pushbutton starts a halted block.
//
// Ports:
//   CLK      in   system clock, rising edge
//   CLR      in   asynchronous active-high reset
//   QD       in   start pushbutton (asynchronous level)
//   SHORT    in   instruction ends after W1
//   LONG     in   instruction extends to W3
//   STOP     in   halt after the current beat
//   STEP     in   (only with STEP_MODE_EN) halt at every instruction end
//   T[2:0]   out  one-hot phase, bit0=T1 .. bit2=T3; 000 when halted
//   W[2:0]   out  one-hot beat,  bit0=W1 .. bit2=W3
//   RUN      out  phases advancing
//   CYC_END  out  high during the last T3 of an instruction cycle
//
// Optional feature macro: STEP_MODE_EN adds the STEP input.
module beat_timer (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       QD,
    input  logic       SHORT,
    input  logic       LONG,
    input  logic       STOP,
`ifdef STEP_MODE_EN
    input  logic       STEP,
`endif
    output logic [2:0] T,
    output logic [2:0] W,
    output logic       RUN,
    output logic       CYC_END
);

    typedef enum logic [2:0] {
        W1 = 3'b001,
        W2 = 3'b010,
        W3 = 3'b100
    } beat_e;

    localparam logic [2:0] PH_T1 = 3'b001;
    localparam logic [2:0] PH_T2 = 3'b010;
    localparam logic [2:0] PH_T3 = 3'b100;

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       edge_q,  edge_d;
    logic [2:0] arm_q,   arm_d;
    logic       run_q,   run_d;
    logic [2:0] t_q,     t_d;
    beat_e      w_q,     w_d;

    logic       qd_rise;
    logic       at_t3;
    logic       cyc_end;
    logic       halt;
    beat_e      w_nxt;

    always_comb begin
        // The synchronizer is cleared by CLR, so for the first clocks after
        // reset its output does not yet reflect the pin. Edge detection is
        // held off until the pipe has refilled, otherwise a QD level that was
        // already high would look like a fresh press.
        qd_rise = sync2_q & ~edge_q & arm_q[2];
        at_t3   = run_q & t_q[2];

        unique case (w_q)
            W1:      w_nxt = SHORT ? W1 : W2;
            W2:      w_nxt = LONG  ? W3 : W1;
            default: w_nxt = W1;
        endcase

        cyc_end = at_t3 && (w_nxt == W1);
`ifdef STEP_MODE_EN
        halt    = STOP | (STEP & cyc_end);
`else
        halt    = STOP;
`endif

        sync1_d = QD;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        arm_d   = {arm_q[1:0], 1'b1};
        run_d   = run_q;
        t_d     = t_q;
        w_d     = w_q;

        if (run_q) begin
            if (at_t3) begin
                // W changes on the same edge that drops T3.
                w_d = w_nxt;
                if (halt) begin
                    run_d = 1'b0;
                    t_d   = 3'b000;
                end else begin
                    t_d   = PH_T1;
                end
            end else begin
                t_d = t_q[0] ? PH_T2 : PH_T3;
            end
        end else if (qd_rise) begin
            // Edges seen while running are simply consumed by edge_q.
            run_d = 1'b1;
            t_d   = PH_T1;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            arm_q   <= 3'b000;
            run_q   <= 1'b0;
            t_q     <= 3'b000;
            w_q     <= W1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
            arm_q   <= arm_d;
            run_q   <= run_d;
            t_q     <= t_d;
            w_q     <= w_d;
        end
    end

    assign T       = t_q;
    assign W       = w_q;
    assign RUN     = run_q;
    assign CYC_END = cyc_end;

endmodule
